// File: rtl/br_pkg.sv
// Shared types and defaults for the pre-FIFO admission/read sequencer.
// Holds the write-FSM encoding and the decision applied to a beat that carries SOF.
package br_pkg;

   localparam int BR_DEPTH         = 1024;
   localparam int BR_USEDW_W       = 11;
   localparam int BR_MAX_FRM_BEATS = 300;
   localparam int BR_DESYNC_CYC    = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PASS = 2'd1,
      ST_DROP = 2'd2
   } br_state_e;

   typedef struct packed {
      br_state_e nxt;
      logic      wren;
      logic      frm;
      logic      drop;
      logic      trunc;
   } wr_dec_t;

   // A beat seen from IDLE: an SOF either opens an admitted frame or a dropped one.
   // A beat without SOF is discarded.
   function automatic wr_dec_t sof_eval(input logic sof, input logic eof, input logic ok);
      wr_dec_t d;
      d.nxt   = ST_IDLE;
      d.wren  = 1'b0;
      d.frm   = 1'b0;
      d.drop  = 1'b0;
      d.trunc = 1'b0;
      if (sof) begin
         if (ok) begin
            d.wren = 1'b1;
            d.frm  = 1'b1;
            d.nxt  = eof ? ST_IDLE : ST_PASS;
         end else begin
            d.drop = 1'b1;
            d.nxt  = eof ? ST_IDLE : ST_DROP;
         end
      end
      return d;
   endfunction

endpackage

// File: rtl/br_evt_cnt32.sv
// 32-bit wrapping event counter; a clear wins over a same-cycle increment.
module br_evt_cnt32 (
   input  logic        clk,
   input  logic        reset_,
   input  logic        clr,
   input  logic        inc,
   output logic [31:0] cnt
);

   always_ff @(posedge clk) begin
      if (!reset_)   cnt <= '0;
      else if (clr)  cnt <= '0;
      else if (inc)  cnt <= cnt + 32'd1;
   end

endmodule

// File: rtl/br_pre_fifo_ctrl.sv
// Frame admission / truncation for the paired reorder pre-FIFOs and the shared
// read enable with data/ctrl desync detection.
module br_pre_fifo_ctrl
   import br_pkg::*;
#(
   parameter int DEPTH         = BR_DEPTH,
   parameter int USEDW_W       = BR_USEDW_W,
   parameter int MAX_FRM_BEATS = BR_MAX_FRM_BEATS,
   parameter int DESYNC_CYC    = BR_DESYNC_CYC
) (
   input  logic               x_clk,
   input  logic               reset_,
   input  logic               init_done,
   input  logic               x_we,
   input  logic               in_sof,
   input  logic               in_eof,
   input  logic [USEDW_W-1:0] wrusedw_d,
   input  logic [USEDW_W-1:0] wrusedw_c,
   input  logic               wrfull_d,
   input  logic               wrfull_c,
   output logic               fifo_wren,
   input  logic               rd_empty_d,
   input  logic               rd_empty_c,
   input  logic [USEDW_W-1:0] rdusedw_d,
   input  logic [USEDW_W-1:0] rdusedw_c,
   input  logic               rd_ready,
   output logic               br_rd_en,
   output logic               desync_err,
   input  logic               cnt_clr,
   output logic [31:0]        frm_cnt,
   output logic [31:0]        drop_cnt,
   output logic [31:0]        trunc_cnt
);

   // Admitting only below this fill guarantees room for a worst-case frame.
   localparam logic [USEDW_W-1:0] ADMIT_LIM = USEDW_W'(DEPTH - MAX_FRM_BEATS);
   localparam int MW = $clog2(DESYNC_CYC + 1);

   br_state_e          state;
   wr_dec_t            dec;
   logic [USEDW_W-1:0] used;
   logic               full;
   logic               admit_ok;
   logic               mismatch;
   logic [MW-1:0]      mis_cnt;

   assign used     = (wrusedw_d > wrusedw_c) ? wrusedw_d : wrusedw_c;
   assign full     = wrfull_d | wrfull_c;
   assign admit_ok = init_done & (used <= ADMIT_LIM) & ~full;

   always_ff @(posedge x_clk) begin
      if (!reset_) state <= ST_IDLE;
      else         state <= dec.nxt;
   end

   always_comb begin
      dec.nxt   = state;
      dec.wren  = 1'b0;
      dec.frm   = 1'b0;
      dec.drop  = 1'b0;
      dec.trunc = 1'b0;
      if (x_we) begin
         unique case (state)
            ST_IDLE: dec = sof_eval(in_sof, in_eof, admit_ok);
            ST_PASS: begin
               if (full) begin
                  dec.trunc = 1'b1;
                  dec.nxt   = in_eof ? ST_IDLE : ST_DROP;
               end else if (in_sof) begin
                  // New SOF before EOF: close the old frame as truncated, start fresh.
                  dec       = sof_eval(in_sof, in_eof, admit_ok);
                  dec.trunc = 1'b1;
               end else begin
                  dec.wren = 1'b1;
                  dec.nxt  = in_eof ? ST_IDLE : ST_PASS;
               end
            end
            ST_DROP: begin
               if (in_eof)      dec.nxt = ST_IDLE;
               else if (in_sof) dec = sof_eval(in_sof, in_eof, admit_ok);
            end
            default: dec.nxt = ST_IDLE;
         endcase
      end
   end

   assign fifo_wren = reset_ & dec.wren;

   assign br_rd_en = reset_ & init_done & ~rd_empty_d & ~rd_empty_c & rd_ready & ~desync_err;

   assign mismatch = (rdusedw_d != rdusedw_c) | (rd_empty_d ^ rd_empty_c);

   always_ff @(posedge x_clk) begin
      if (!reset_) begin
         mis_cnt    <= '0;
         desync_err <= 1'b0;
      end else if (mismatch) begin
         if (int'(mis_cnt) < DESYNC_CYC) mis_cnt <= mis_cnt + 1'b1;
         if (int'(mis_cnt) + 1 >= DESYNC_CYC) desync_err <= 1'b1;
      end else begin
         mis_cnt <= '0;
      end
   end

   br_evt_cnt32 u_frm_cnt (
      .clk(x_clk), .reset_(reset_), .clr(cnt_clr), .inc(dec.frm), .cnt(frm_cnt)
   );
   br_evt_cnt32 u_drop_cnt (
      .clk(x_clk), .reset_(reset_), .clr(cnt_clr), .inc(dec.drop), .cnt(drop_cnt)
   );
   br_evt_cnt32 u_trunc_cnt (
      .clk(x_clk), .reset_(reset_), .clr(cnt_clr), .inc(dec.trunc), .cnt(trunc_cnt)
   );

endmodule

// File: tb/tb_br_pre_fifo_ctrl.sv
// Directed bench for br_pre_fifo_ctrl: the driver queues expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_br_pre_fifo_ctrl;

   localparam int W = 11;
   localparam int K_WREN = 0, K_RDEN = 1, K_FRM = 2, K_DROP = 3, K_TRUNC = 4, K_DSYNC = 5;

   logic          x_clk = 1'b0;
   logic          reset_, init_done, x_we, in_sof, in_eof;
   logic [W-1:0]  wrusedw_d, wrusedw_c, rdusedw_d, rdusedw_c;
   logic          wrfull_d, wrfull_c, fifo_wren;
   logic          rd_empty_d, rd_empty_c, rd_ready, br_rd_en, desync_err, cnt_clr;
   logic [31:0]   frm_cnt, drop_cnt, trunc_cnt;

   typedef struct {
      int          cyc;
      int          kind;
      logic [31:0] val;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 x_clk = ~x_clk;
   always @(posedge x_clk) cyc <= cyc + 1;

   br_pre_fifo_ctrl dut (
      .x_clk(x_clk), .reset_(reset_), .init_done(init_done), .x_we(x_we),
      .in_sof(in_sof), .in_eof(in_eof), .wrusedw_d(wrusedw_d), .wrusedw_c(wrusedw_c),
      .wrfull_d(wrfull_d), .wrfull_c(wrfull_c), .fifo_wren(fifo_wren),
      .rd_empty_d(rd_empty_d), .rd_empty_c(rd_empty_c), .rdusedw_d(rdusedw_d),
      .rdusedw_c(rdusedw_c), .rd_ready(rd_ready), .br_rd_en(br_rd_en),
      .desync_err(desync_err), .cnt_clr(cnt_clr), .frm_cnt(frm_cnt),
      .drop_cnt(drop_cnt), .trunc_cnt(trunc_cnt)
   );

   function automatic logic [31:0] act(int k);
      case (k)
         K_WREN:  return 32'(fifo_wren);
         K_RDEN:  return 32'(br_rd_en);
         K_FRM:   return frm_cnt;
         K_DROP:  return drop_cnt;
         K_TRUNC: return trunc_cnt;
         default: return 32'(desync_err);
      endcase
   endfunction

   function automatic string kname(int k);
      case (k)
         K_WREN:  return "fifo_wren";
         K_RDEN:  return "br_rd_en";
         K_FRM:   return "frm_cnt";
         K_DROP:  return "drop_cnt";
         K_TRUNC: return "trunc_cnt";
         default: return "desync_err";
      endcase
   endfunction

   always @(negedge x_clk) begin
      exp_t e;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         e = q.pop_front();
         n_cmp++;
         if (e.cyc != cyc) begin
            n_err++;
            $display("FAIL %s stale check queued cyc %0d seen cyc %0d", kname(e.kind), e.cyc, cyc);
         end else if (act(e.kind) !== e.val) begin
            n_err++;
            $display("FAIL %s cyc %0d: got %0d expected %0d", kname(e.kind), cyc, act(e.kind), e.val);
         end
      end
   end

   task automatic push(int k, logic [31:0] v);
      exp_t e;
      e.cyc = cyc; e.kind = k; e.val = v;
      q.push_back(e);
   endtask

   task automatic step();
      @(posedge x_clk);
      #1;
   endtask

   task automatic beat(logic sof, logic eof, logic full_d, logic ew);
      step();
      x_we = 1'b1; in_sof = sof; in_eof = eof; wrfull_d = full_d;
      push(K_WREN, 32'(ew));
   endtask

   task automatic idle();
      step();
      x_we = 1'b0; in_sof = 1'b0; in_eof = 1'b0; wrfull_d = 1'b0;
   endtask

   task automatic rd(logic rdy, logic [W-1:0] ud, logic [W-1:0] uc, logic ed, logic ec, logic er);
      step();
      x_we = 1'b0; rd_ready = rdy; rdusedw_d = ud; rdusedw_c = uc; rd_empty_d = ed; rd_empty_c = ec;
      push(K_RDEN, 32'(er));
   endtask

   task automatic counts(int f, int d, int t);
      push(K_FRM, f); push(K_DROP, d); push(K_TRUNC, t);
   endtask

   initial begin
      reset_ = 1'b0; init_done = 1'b1; x_we = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
      wrusedw_d = '0; wrusedw_c = '0; wrfull_d = 1'b0; wrfull_c = 1'b0;
      rd_empty_d = 1'b1; rd_empty_c = 1'b1; rdusedw_d = '0; rdusedw_c = '0;
      rd_ready = 1'b0; cnt_clr = 1'b0;
      repeat (2) step();

      // reset holds everything off even with an admissible SOF and readable FIFOs
      step();
      x_we = 1'b1; in_sof = 1'b1; rd_empty_d = 1'b0; rd_empty_c = 1'b0; rd_ready = 1'b1;
      push(K_WREN, 0); push(K_RDEN, 0); counts(0, 0, 0); push(K_DSYNC, 0);
      step();
      reset_ = 1'b1; x_we = 1'b0; in_sof = 1'b0; rd_empty_d = 1'b1; rd_empty_c = 1'b1; rd_ready = 1'b0;

      // 4-beat frame, then a stray non-SOF beat proves return to IDLE
      beat(1, 0, 0, 1); beat(0, 0, 0, 1); beat(0, 0, 0, 1); beat(0, 1, 0, 1);
      beat(0, 0, 0, 0);
      idle(); counts(1, 0, 0);

      // admission threshold 724, using max of both used counts
      wrusedw_d = 11'd725;
      beat(1, 0, 0, 0); beat(0, 0, 0, 0); beat(0, 0, 0, 0); beat(0, 0, 0, 0); beat(0, 1, 0, 0);
      idle(); wrusedw_d = 11'd0; wrusedw_c = 11'd725;
      beat(1, 1, 0, 0);
      idle(); wrusedw_d = 11'd700; wrusedw_c = 11'd724;
      beat(1, 0, 0, 1); beat(0, 1, 0, 1);
      idle(); counts(2, 2, 0); wrusedw_d = '0; wrusedw_c = '0;

      // full on beat 2 truncates; next frame admitted normally
      beat(1, 0, 0, 1); beat(0, 0, 0, 1); beat(0, 0, 1, 0); beat(0, 0, 0, 0); beat(0, 0, 0, 0);
      beat(0, 1, 0, 0);
      idle(); counts(3, 2, 1);
      beat(1, 0, 0, 1); beat(0, 1, 0, 1);
      idle(); counts(4, 2, 1);

      // single-beat frames back to back, then SOF without prior EOF
      beat(1, 1, 0, 1); beat(1, 1, 0, 1); beat(1, 1, 0, 1);
      idle(); counts(7, 2, 1);
      beat(1, 0, 0, 1); beat(0, 0, 0, 1); beat(1, 0, 0, 1); beat(0, 1, 0, 1);
      idle(); counts(9, 2, 2);

      // ctrl FIFO full at SOF drops the frame
      step(); x_we = 1'b1; in_sof = 1'b1; in_eof = 1'b1; wrfull_c = 1'b1; push(K_WREN, 0);
      idle(); wrfull_c = 1'b0; counts(9, 3, 2);

      // init_done falling mid-frame: frame finishes, next SOF dropped
      beat(1, 0, 0, 1); beat(0, 0, 0, 1); init_done = 1'b0;
      beat(0, 1, 0, 1); beat(1, 1, 0, 0);
      idle(); counts(10, 4, 2); init_done = 1'b1;

      // read gating
      rd(1, 8, 8, 0, 0, 1); rd(0, 8, 8, 0, 0, 0); rd(1, 8, 8, 0, 0, 1); rd(0, 8, 8, 0, 0, 0);
      rd(1, 8, 8, 0, 0, 0); init_done = 1'b0;
      rd(1, 8, 8, 0, 0, 1); init_done = 1'b1;
      rd(1, 8, 8, 0, 1, 0); rd(1, 8, 8, 0, 0, 1); push(K_DSYNC, 0);
      rd(1, 5, 4, 0, 0, 1); rd(1, 8, 8, 0, 0, 1); push(K_DSYNC, 0);
      rd(1, 5, 4, 0, 0, 1); rd(1, 5, 4, 0, 0, 1);
      rd(1, 8, 8, 0, 0, 0); push(K_DSYNC, 1);
      rd(1, 8, 8, 0, 0, 0); rd(1, 8, 8, 0, 0, 0); push(K_DSYNC, 1);

      // clear beats a same-cycle drop
      wrusedw_d = 11'd725;
      beat(1, 1, 0, 0); cnt_clr = 1'b1;
      idle(); cnt_clr = 1'b0; wrusedw_d = '0; counts(0, 0, 0);

      // reset mid-frame
      beat(1, 0, 0, 1); beat(0, 0, 0, 1); push(K_FRM, 1);
      step(); reset_ = 1'b0; x_we = 1'b1; push(K_WREN, 0);
      step(); reset_ = 1'b1; x_we = 1'b0; counts(0, 0, 0); push(K_DSYNC, 0); push(K_RDEN, 1);
      beat(0, 0, 0, 0); beat(0, 1, 0, 0);
      idle(); counts(0, 0, 0);

      idle();
      for (int i = 0; i < 10 && q.size() > 0; i++) step();
      if (q.size() > 0) begin
         n_cmp++; n_err++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
